// File: rtl/jb_poll_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jb_poll_sched_if : scheduler <-> JOYBUS host transceiver TX/RX link
// Rev 1.0
// ---------------------------------------------------------------------------
interface jb_poll_sched_if;
  logic        tx_start;
  logic [7:0]  tx_cmd;
  logic        tx_done;
  logic        rx_done;
  logic [31:0] rx_data;

  modport master (output tx_start, tx_cmd, input tx_done, rx_done, rx_data);
  modport slave  (input tx_start, tx_cmd, output tx_done, rx_done, rx_data);
endinterface
`default_nettype wire

// File: rtl/jb_poll_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jb_poll_sched : periodic poll / software command scheduler for JOYBUS host
// Optional statistics counters: define JB_SCHED_STATS_EN.   Rev 1.0
// ---------------------------------------------------------------------------
module jb_poll_sched #(
  parameter int POLL_PERIOD = 416667,
  parameter int RX_TIMEOUT  = 2500,
  parameter int GAP_CYCLES  = 50,
  parameter int MAX_RETRY   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            poll_en,
  input  logic            cmd_req,
  input  logic [7:0]      cmd_byte,
  output logic            cmd_ack,
  jb_poll_sched_if.master host,
  output logic [31:0]     resp_data,
  output logic [7:0]      resp_cmd,
  output logic            resp_valid,
  output logic            timeout_err,
  output logic            btn_A,
  output logic            btn_B,
  output logic            btn_Z,
  output logic            btn_S,
  output logic            busy
`ifdef JB_SCHED_STATS_EN
  ,
  output logic [15:0]     poll_count,
  output logic [15:0]     retry_count,
  output logic [15:0]     err_count
`endif
);

  localparam int PW   = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TMAX = (RX_TIMEOUT > GAP_CYCLES) ? RX_TIMEOUT : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(RX_TIMEOUT - 2);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  localparam logic [7:0]    POLL_CMD  = 8'h01;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TX, WAIT_RX, GAP} state_t;

  state_t        state;
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] tmr;
  logic [RW-1:0] retry_cnt;
  logic          retry_pend;
  logic [3:0]    btn;
  logic          poll_due;
  logic          poll_launch;

  assign poll_due    = (poll_cnt == POLL_LAST);
  assign poll_launch = (state == IDLE) && !cmd_req && poll_due;
  assign busy        = (state != IDLE);
  assign {btn_A, btn_B, btn_Z, btn_S} = btn;

  always_ff @(posedge clk) begin
    if (rst || !poll_en || poll_launch)
      poll_cnt <= '0;
    else if (!poll_due)
      poll_cnt <= poll_cnt + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      retry_cnt     <= '0;
      retry_pend    <= 1'b0;
      host.tx_start <= 1'b0;
      host.tx_cmd   <= 8'h00;
      cmd_ack       <= 1'b0;
      resp_data     <= '0;
      resp_cmd      <= 8'h00;
      resp_valid    <= 1'b0;
      timeout_err   <= 1'b0;
      btn           <= 4'h0;
    end else begin
      host.tx_start <= 1'b0;
      cmd_ack       <= 1'b0;
      resp_valid    <= 1'b0;
      timeout_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            host.tx_cmd   <= cmd_byte;
            host.tx_start <= 1'b1;
            cmd_ack       <= 1'b1;
            retry_cnt     <= '0;
            state         <= ISSUE;
          end else if (poll_due) begin
            host.tx_cmd   <= POLL_CMD;
            host.tx_start <= 1'b1;
            retry_cnt     <= '0;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_TX;
        WAIT_TX: begin
          // The response window spans RX_TIMEOUT cycles starting at the tx_done cycle.
          if (host.tx_done) begin
            tmr   <= TMO_LOAD;
            state <= WAIT_RX;
          end
        end
        WAIT_RX: begin
          if (host.rx_done) begin
            resp_data  <= host.rx_data;
            resp_cmd   <= host.tx_cmd;
            resp_valid <= 1'b1;
            if (host.tx_cmd == POLL_CMD)
              btn <= host.rx_data[31:28];
            retry_pend <= 1'b0;
            tmr        <= GAP_LOAD;
            state      <= GAP;
          end else if (tmr == '0) begin
            if (retry_cnt != RETRY_LIM) begin
              retry_cnt  <= retry_cnt + RW'(1);
              retry_pend <= 1'b1;
            end else begin
              timeout_err <= 1'b1;
              retry_pend  <= 1'b0;
            end
            tmr   <= GAP_LOAD;
            state <= GAP;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        GAP: begin
          // A pending retry reissues the same byte without re-arbitrating.
          if (tmr == '0) begin
            if (retry_pend) begin
              host.tx_start <= 1'b1;
              retry_pend    <= 1'b0;
              state         <= ISSUE;
            end else begin
              state <= IDLE;
            end
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JB_SCHED_STATS_EN
  logic retry_evt;
  assign retry_evt = (state == WAIT_RX) && !host.rx_done && (tmr == '0) &&
                     (retry_cnt != RETRY_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_count  <= 16'h0000;
      retry_count <= 16'h0000;
      err_count   <= 16'h0000;
    end else begin
      if (resp_valid && (resp_cmd == POLL_CMD) && (poll_count != 16'hFFFF))
        poll_count <= poll_count + 16'd1;
      if (retry_evt && (retry_count != 16'hFFFF))
        retry_count <= retry_count + 16'd1;
      if (timeout_err && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_jb_poll_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jb_poll_sched : randomized bench with a transaction-level reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_jb_poll_sched;
  localparam int PP  = 100;
  localparam int RXT = 40;
  localparam int GAP = 8;
  localparam int MR  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        poll_en = 1'b0;
  logic        cmd_req = 1'b0;
  logic [7:0]  cmd_byte = 8'h00;
  logic        cmd_ack, resp_valid, timeout_err, busy;
  logic        btn_A, btn_B, btn_Z, btn_S;
  logic [31:0] resp_data;
  logic [7:0]  resp_cmd;
`ifdef JB_SCHED_STATS_EN
  logic [15:0] poll_count, retry_count, err_count;
`endif

  jb_poll_sched_if bus();

  jb_poll_sched #(.POLL_PERIOD(PP), .RX_TIMEOUT(RXT), .GAP_CYCLES(GAP), .MAX_RETRY(MR)) dut (
    .clk(clk), .rst(rst), .poll_en(poll_en), .cmd_req(cmd_req), .cmd_byte(cmd_byte),
    .cmd_ack(cmd_ack), .host(bus), .resp_data(resp_data), .resp_cmd(resp_cmd),
    .resp_valid(resp_valid), .timeout_err(timeout_err), .btn_A(btn_A), .btn_B(btn_B),
    .btn_Z(btn_Z), .btn_S(btn_S), .busy(busy)
`ifdef JB_SCHED_STATS_EN
    , .poll_count(poll_count), .retry_count(retry_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Host transceiver behaviour for one attempt: tx_done dtx cycles after tx_start,
  // then (if ans) rx_done drx cycles after tx_done.
  typedef struct {
    int          dtx;
    bit          ans;
    int          drx;
    logic [31:0] data;
  } act_t;

  act_t host_q[$];

  initial begin : host_model
    act_t a;
    bus.tx_done = 1'b0;
    bus.rx_done = 1'b0;
    bus.rx_data = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (host_q.size() > 0) a = host_q.pop_front();
        else a = '{dtx: 1, ans: 1'b0, drx: 1, data: 32'h0};
        repeat (a.dtx) @(posedge clk);
        #1 bus.tx_done = 1'b1;
        @(posedge clk);
        #1 bus.tx_done = 1'b0;
        if (a.ans) begin
          repeat (a.drx - 1) @(posedge clk);
          #1;
          bus.rx_done = 1'b1;
          bus.rx_data = a.data;
          @(posedge clk);
          #1;
          bus.rx_done = 1'b0;
          bus.rx_data = $urandom;
        end
      end
    end
  end

  int          ts_q[$], ack_q[$], rv_q[$], err_q[$];
  logic [7:0]  tc_q[$], rvc_q[$];
  logic [31:0] rvd_q[$];

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      ts_q.push_back(cyc);
      tc_q.push_back(bus.tx_cmd);
    end
    if (cmd_ack === 1'b1) ack_q.push_back(cyc);
    if (resp_valid === 1'b1) begin
      rv_q.push_back(cyc);
      rvd_q.push_back(resp_data);
      rvc_q.push_back(resp_cmd);
    end
    if (timeout_err === 1'b1) err_q.push_back(cyc);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic goto_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [3:0]  btn_m  = 4'h0;
  logic [31:0] rdata_m = 32'h0;
  logic [7:0]  rcmd_m = 8'h00;
  act_t        att[MR+1];

  task automatic check_outputs(input string tag);
    check_val({tag, "_resp_data"}, resp_data, rdata_m);
    check_val({tag, "_resp_cmd"}, resp_cmd, rcmd_m);
    check_val({tag, "_buttons"}, {btn_A, btn_B, btn_Z, btn_S}, btn_m);
  endtask

  // Software command; timing predicted from the attempt list in att[].
  task automatic run_txn(input logic [7:0] b);
    int q, s, d, e, n_exp, rv_c, err_c, end_c;
    int tb0, ab0, rb0, eb0;
    int exp_s[MR+1];
    bit ok;
    logic [31:0] ok_data;
    tb0 = ts_q.size(); ab0 = ack_q.size(); rb0 = rv_q.size(); eb0 = err_q.size();
    @(posedge clk);
    #1;
    q = cyc;
    s = q + 1; n_exp = 0; ok = 1'b0; rv_c = -1; err_c = -1; end_c = q; ok_data = 32'h0;
    for (int k = 0; k <= MR; k++) begin
      exp_s[k] = s;
      n_exp++;
      host_q.push_back(att[k]);
      d = s + att[k].dtx;
      if (att[k].ans && att[k].drx <= RXT - 1) begin
        ok = 1'b1; ok_data = att[k].data;
        rv_c = d + att[k].drx + 1;
        end_c = rv_c + GAP - 1;
        break;
      end
      e = d + RXT - 1;
      end_c = e + GAP;
      if (k == MR) err_c = e + 1;
      else s = e + GAP + 1;
    end
    cmd_req = 1'b1;
    cmd_byte = b;
    goto_cycle(q + 2);
    cmd_req = 1'b0;
    goto_cycle(end_c + 3);
    if (ok) begin
      rdata_m = ok_data;
      rcmd_m = b;
      if (b == 8'h01) btn_m = ok_data[31:28];
    end
    check_val("txn_starts", ts_q.size() - tb0, n_exp);
    for (int k = 0; k < n_exp; k++) begin
      if (tb0 + k < ts_q.size()) begin
        check_val("txn_start_cyc", ts_q[tb0 + k], exp_s[k]);
        check_val("txn_tx_cmd", tc_q[tb0 + k], b);
      end
    end
    check_val("txn_acks", ack_q.size() - ab0, 1);
    if (ack_q.size() > ab0) check_val("txn_ack_cyc", ack_q[ab0], q + 1);
    check_val("txn_resp_valids", rv_q.size() - rb0, ok);
    if (ok && rv_q.size() > rb0) begin
      check_val("txn_rv_cyc", rv_q[rb0], rv_c);
      check_val("txn_rv_data", rvd_q[rb0], ok_data);
      check_val("txn_rv_cmd", rvc_q[rb0], b);
    end
    check_val("txn_timeouts", err_q.size() - eb0, !ok);
    if (!ok && err_q.size() > eb0) check_val("txn_err_cyc", err_q[eb0], err_c);
    check_outputs("txn");
    check_val("txn_idle", busy, 1'b0);
  endtask

  task automatic set_att(input int k, input int dtx, input bit ans, input int drx,
                         input logic [31:0] data);
    att[k] = '{dtx: dtx, ans: ans, drx: drx, data: data};
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int c0, s1, d1, r1, s2, rv2, q, tb0, ab0, rb0, eb0, r;
    logic [31:0] x;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_tx_start", bus.tx_start, 1'b0);
    check_val("rst_tx_cmd", bus.tx_cmd, 8'h00);
    check_val("rst_flags", {cmd_ack, resp_valid, timeout_err}, 3'b000);
    check_outputs("rst");
    rst = 1'b0;
    goto_cycle(cyc + 3);

    // Periodic poll only; software request raised and withdrawn while busy.
    tb0 = ts_q.size(); ab0 = ack_q.size(); rb0 = rv_q.size();
    host_q.push_back('{dtx: 3, ans: 1'b1, drx: 7, data: 32'hA500_0000});
    @(posedge clk);
    #1;
    c0 = cyc;
    poll_en = 1'b1;
    s1 = c0 + PP;
    r1 = s1 + 3 + 7;
    goto_cycle(s1 + 2);
    check_val("poll_busy_mid", busy, 1'b1);
    poll_en = 1'b0;
    cmd_req = 1'b1;
    cmd_byte = 8'h00;
    goto_cycle(s1 + 5);
    cmd_req = 1'b0;
    goto_cycle(r1 + GAP + PP + 20);
    check_val("poll_starts", ts_q.size() - tb0, 1);
    if (ts_q.size() > tb0) begin
      check_val("poll_start_cyc", ts_q[tb0], s1);
      check_val("poll_tx_cmd", tc_q[tb0], 8'h01);
    end
    check_val("poll_withdrawn_acks", ack_q.size() - ab0, 0);
    check_val("poll_resp_valids", rv_q.size() - rb0, 1);
    if (rv_q.size() > rb0) check_val("poll_rv_cyc", rv_q[rb0], r1 + 1);
    check_val("poll_btn_A", btn_A, 1'b1);
    check_val("poll_btn_B", btn_B, 1'b0);
    check_val("poll_btn_Z", btn_Z, 1'b1);
    check_val("poll_btn_S", btn_S, 1'b0);
    btn_m = 4'hA; rdata_m = 32'hA500_0000; rcmd_m = 8'h01;
    check_outputs("poll");

    // Software command raised the cycle poll_due asserts wins; poll follows after the gap.
    tb0 = ts_q.size(); ab0 = ack_q.size(); rb0 = rv_q.size();
    x = $urandom;
    host_q.push_back('{dtx: 2, ans: 1'b1, drx: 6, data: 32'h1234_5678});
    host_q.push_back('{dtx: 4, ans: 1'b1, drx: 9, data: x});
    @(posedge clk);
    #1;
    c0 = cyc;
    poll_en = 1'b1;
    goto_cycle(c0 + PP - 1);
    cmd_req = 1'b1;
    cmd_byte = 8'hFF;
    s1 = c0 + PP; d1 = s1 + 2; r1 = d1 + 6; s2 = r1 + GAP + 2; rv2 = s2 + 4 + 9 + 1;
    goto_cycle(s1 + 1);
    cmd_req = 1'b0;
    goto_cycle(r1 + 1);
    check_val("arb_rv_pulse", resp_valid, 1'b1);
    rdata_m = 32'h1234_5678; rcmd_m = 8'hFF;
    check_outputs("arb_ff");
    goto_cycle(s2 + 1);
    poll_en = 1'b0;
    goto_cycle(rv2 + GAP + 5);
    check_val("arb_starts", ts_q.size() - tb0, 2);
    if (ts_q.size() > tb0 + 1) begin
      check_val("arb_first_cyc", ts_q[tb0], s1);
      check_val("arb_first_cmd", tc_q[tb0], 8'hFF);
      check_val("arb_poll_cyc", ts_q[tb0 + 1], s2);
      check_val("arb_poll_cmd", tc_q[tb0 + 1], 8'h01);
    end
    check_val("arb_acks", ack_q.size() - ab0, 1);
    if (ack_q.size() > ab0) check_val("arb_ack_cyc", ack_q[ab0], s1);
    check_val("arb_resp_valids", rv_q.size() - rb0, 2);
    if (rv_q.size() > rb0 + 1) check_val("arb_rv2_cyc", rv_q[rb0 + 1], rv2);
    rdata_m = x; rcmd_m = 8'h01; btn_m = x[31:28];
    check_outputs("arb_poll");

    // Retry: first attempt silent, second answers.
    set_att(0, 2, 1'b0, 1, 32'h0);
    set_att(1, 3, 1'b1, 5, 32'h8000_0000);
    set_att(2, 1, 1'b0, 1, 32'h0);
    run_txn(8'h01);
    check_val("retry_btn_A", btn_A, 1'b1);

    // Exhaustion: all attempts silent.
    set_att(0, 1, 1'b0, 1, 32'h0);
    set_att(1, 5, 1'b0, 1, 32'h0);
    set_att(2, 2, 1'b0, 1, 32'h0);
    run_txn(8'h01);

    // rx_done coincident with timeout expiry is accepted.
    set_att(0, 2, 1'b1, RXT - 1, 32'h7E57_0001);
    run_txn(8'h00);

    // rx_done one cycle past the window is a stray, then the retry answers.
    set_att(0, 2, 1'b1, RXT, 32'hDEAD_BEEF);
    set_att(1, 1, 1'b1, 3, 32'h4000_0000);
    run_txn(8'h01);

    for (int n = 0; n < 20; n++) begin
      r = $urandom_range(0, 3);
      b = (r == 0) ? 8'h00 : (r == 1) ? 8'h01 : (r == 2) ? 8'hFF : 8'($urandom);
      for (int k = 0; k <= MR; k++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       set_att(k, $urandom_range(1, 6), 1'b1, $urandom_range(1, RXT - 1), $urandom);
        else if (r == 6) set_att(k, $urandom_range(1, 6), 1'b1, RXT - 1, $urandom);
        else if (r == 7) set_att(k, $urandom_range(1, 6), 1'b1, $urandom_range(RXT, RXT + GAP - 1), $urandom);
        else             set_att(k, $urandom_range(1, 6), 1'b0, 1, 32'h0);
      end
      run_txn(b);
    end

    // Reset while waiting for a response; the late rx_done must be ignored.
    tb0 = ts_q.size(); rb0 = rv_q.size(); eb0 = err_q.size();
    host_q.push_back('{dtx: 2, ans: 1'b1, drx: 20, data: 32'hF000_0000 | $urandom});
    @(posedge clk);
    #1;
    q = cyc;
    cmd_req = 1'b1;
    cmd_byte = 8'h01;
    goto_cycle(q + 2);
    cmd_req = 1'b0;
    goto_cycle(q + 8);
    rst = 1'b1;
    goto_cycle(q + 9);
    rst = 1'b0;
    btn_m = 4'h0; rdata_m = 32'h0; rcmd_m = 8'h00;
    check_val("rstmid_busy", busy, 1'b0);
    check_val("rstmid_tx_cmd", bus.tx_cmd, 8'h00);
    check_outputs("rstmid");
    goto_cycle(q + 60);
    check_val("rstmid_starts", ts_q.size() - tb0, 1);
    check_val("rstmid_resp_valids", rv_q.size() - rb0, 0);
    check_val("rstmid_timeouts", err_q.size() - eb0, 0);
    check_outputs("rstmid_late");

    set_att(0, 3, 1'b1, 4, 32'h9000_0001);
    run_txn(8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/jb_poll_sched.md
Name: jb_poll_sched

Overview:
- Scheduler that sequences the JOYBUS host transceiver. It issues a periodic controller poll (0x01) and arbitrates it against one-shot software commands (e.g. 0x00 info, 0xFF reset).
- Enforces the response timeout, retries failed transactions, and publishes the latest 32-bit response plus decoded A/B/Z/Start buttons.
- Sits between top-level control logic and the JOYBUS host TX/RX datapath.

Parameters:
- POLL_PERIOD, 416667: clk cycles between poll launches (60 Hz at 25 MHz).
- RX_TIMEOUT, 2500: clk cycles allowed from tx_done to rx_done (100 us).
- GAP_CYCLES, 50: minimum idle cycles after any transaction before the next launch.
- MAX_RETRY, 2: extra attempts after a timeout before reporting an error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- poll_en  in  1  enables periodic polling
- cmd_req  in  1  software command request; held until cmd_ack
- cmd_byte  in  8  software command byte
- cmd_ack  out  1  one-cycle pulse when cmd_req is accepted (launched)
- tx_start  out  1  one-cycle pulse to host TX
- tx_cmd  out  8  command byte; stable from tx_start until tx_done
- tx_done  in  1  one-cycle pulse, host finished transmitting
- rx_done  in  1  one-cycle pulse, response captured
- rx_data  in  32  response word; valid in the rx_done cycle
- resp_data  out  32  last successful response
- resp_cmd  out  8  command that produced resp_data
- resp_valid  out  1  one-cycle pulse on each successful response
- timeout_err  out  1  one-cycle pulse when retries are exhausted
- btn_A, btn_B, btn_Z, btn_S  out  1 each  = resp_data[31:28], updated only by 0x01 responses
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0, tx_cmd = 0x00, state = IDLE, poll counter = 0, retry counter = 0.
- Poll counter:
  - Free-runs while poll_en = 1 and saturates at POLL_PERIOD-1.
  - When saturated, poll_due = 1.
  - Clears to 0 on a poll launch and whenever poll_en = 0.
- States: IDLE, ISSUE, WAIT_TX, WAIT_RX, GAP.
- IDLE:
  - cmd_req has priority over poll_due.
  - On selection: latch the byte (cmd_byte or 0x01) into tx_cmd, clear retry_cnt, go to ISSUE.
  - cmd_ack pulses in the same cycle as the software command's first tx_start.
  - A poll that is due but loses arbitration stays pending and launches after GAP.
- ISSUE: drive tx_start = 1 for exactly one cycle, then go to WAIT_TX.
- WAIT_TX:
  - On tx_done, load the timeout counter with RX_TIMEOUT and go to WAIT_RX.
  - No timeout applies in WAIT_TX.
- WAIT_RX:
  - On rx_done, latency is 1: the next cycle has resp_data = rx_data, resp_cmd = tx_cmd, resp_valid = 1. Buttons update in that same cycle if tx_cmd == 0x01. Then go to GAP.
  - If rx_done and counter expiry occur in the same cycle, rx_done wins.
  - On expiry with retry_cnt < MAX_RETRY: increment retry_cnt, go to GAP, then ISSUE with the same tx_cmd.
  - On expiry with retry_cnt == MAX_RETRY: timeout_err pulses for 1 cycle. resp_data and buttons hold their old values. Go to GAP with no further retry.
- GAP:
  - Counts GAP_CYCLES, then returns to IDLE, or to ISSUE if a retry is pending.
  - A retry does not re-arbitrate, so a pending cmd_req waits.
- Stray pulses: tx_done or rx_done outside its waiting state is ignored.
- Mode changes:
  - poll_en falling mid-transaction does not abort it; only future polls stop.
  - cmd_req dropped before ack is treated as withdrawn.
- Reset mid-transaction: returns to IDLE next cycle with all outputs cleared. No tx_start is issued until a fresh arbitration.

Optional Feature:
- Macro: JB_SCHED_STATS_EN.
- When defined:
  - Extra outputs poll_count[15:0], retry_count[15:0], err_count[15:0].
  - Each increments on resp_valid for 0x01, on each retry, and on timeout_err respectively.
  - Each saturates at 0xFFFF and clears on rst.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Poll only: POLL_PERIOD=100, poll_en=1, host model replies 0xA5000000 -> tx_start at cycle 100 with tx_cmd=0x01; resp_valid 1 cycle after rx_done; btn_A=1, btn_B=0, btn_Z=1, btn_S=0.
- Arbitration: cmd_req with cmd_byte=0xFF raised in the same cycle poll_due asserts -> 0xFF launched first with cmd_ack; 0x01 launched after GAP_CYCLES; buttons unchanged by the 0xFF response 0x12345678.
- Retry: host never answers the first attempt, then answers 0x80000000 -> exactly 2 tx_start pulses; the second follows RX_TIMEOUT+GAP_CYCLES after the first tx_done; btn_A=1; timeout_err never pulses.
- Exhaustion: host silent, MAX_RETRY=2 -> 3 tx_start pulses, 1 timeout_err pulse, resp_valid=0, buttons hold their prior values.
- Collision: rx_done coincident with timeout expiry -> response accepted, no retry.
- Reset in WAIT_RX, then a late rx_done -> outputs stay 0; no resp_valid; next tx_start only after a new arbitration.
